// File: rtl/exe_pkg.sv
// exe_pkg: shared encodings for the execute stage.
//   cmd_e      - ALU opcodes carried on execute_command_in
//   shift_e    - register-operand shift types (shifter[6:5])
//   FLAG_*     - NZCV bit positions within status words
//   fwd_mux    - operand forwarding select (used when EXE_FORWARDING_EN is defined)
package exe_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // 00 and the reserved 11 both keep the ID/EX value
    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] id_val,
                                            input logic [31:0] mem_val, input logic [31:0] wb_val);
        return sel == 2'b01 ? mem_val : sel == 2'b10 ? wb_val : id_val;
    endfunction

endpackage

// File: rtl/val2_generator.sv
// val2_generator: combinational second-operand generator for the execute stage.
//   val_rm             in  register operand to shift
//   shifter_operand    in  12-bit shifter field
//   instr_is_immediate in  selects rotated 8-bit immediate
//   mem_access         in  load/store: zero-extended 12-bit offset
//   val2               out resulting operand
module val2_generator
    import exe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] val_rm,
    input  logic [11:0]       shifter_operand,
    input  logic              instr_is_immediate,
    input  logic              mem_access,
    output logic [DATA_W-1:0] val2
);

    logic [4:0]          amt;
    logic [4:0]          rot;
    logic [DATA_W-1:0]   imm_ext;
    logic [2*DATA_W-1:0] imm_dbl;
    logic [2*DATA_W-1:0] rm_dbl;
    logic [DATA_W-1:0]   shifted;

    // Rotations are taken from the low half of a doubled word shifted right.
    always_comb begin
        amt     = shifter_operand[11:7];
        rot     = {shifter_operand[11:8], 1'b0};
        imm_ext = {{(DATA_W-8){1'b0}}, shifter_operand[7:0]};
        imm_dbl = {imm_ext, imm_ext} >> rot;
        rm_dbl  = {val_rm, val_rm} >> amt;
        shifted = shifter_operand[6:5] == SH_LSL ? val_rm << amt :
                  shifter_operand[6:5] == SH_LSR ? val_rm >> amt :
                  shifter_operand[6:5] == SH_ASR ? DATA_W'($signed(val_rm) >>> amt) :
                                                   rm_dbl[DATA_W-1:0];
        val2    = mem_access         ? {{(DATA_W-12){1'b0}}, shifter_operand} :
                  instr_is_immediate ? imm_dbl[DATA_W-1:0] : shifted;
    end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage ARM pipeline.
// Builds Val2, runs the ALU, owns the NZCV status register, drives the branch
// redirect and registers results into the EX/MEM boundary (1-cycle latency).
//   clk, rst (async, active-low), freeze (hold EX/MEM regs and SR)
//   ID/EX inputs: control bits, execute_command_in, wb_reg_dest_in, pc/branch/operand data,
//                 instr_shifter_opperand_in, status_bits_in (carry-in source)
//   branch_taken_out / branch_address_out: combinational redirect
//   status_reg_out: NZCV register to ID
//   wb_en_out, mem_r_en_out, mem_w_en_out, wb_reg_dest_out, alu_result_out, store_data_out: EX/MEM
// Optional macro EXE_FORWARDING_EN adds fwd_sel_rn/fwd_sel_rm/mem_fwd_value/wb_fwd_value.
module exe_stage
    import exe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  branch_taken_in,
    input  logic                  do_update_sr_in,
    input  logic                  instr_is_immediate_in,
    input  logic [3:0]            execute_command_in,
    input  logic [REG_ADDR_W-1:0] wb_reg_dest_in,
    input  logic [DATA_W-1:0]     pc_plus_four_in,
    input  logic [DATA_W-1:0]     branch_immediate_in,
    input  logic [DATA_W-1:0]     val_rn_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic [11:0]           instr_shifter_opperand_in,
    input  logic [3:0]            status_bits_in,
`ifdef EXE_FORWARDING_EN
    input  logic [1:0]            fwd_sel_rn,
    input  logic [1:0]            fwd_sel_rm,
    input  logic [DATA_W-1:0]     mem_fwd_value,
    input  logic [DATA_W-1:0]     wb_fwd_value,
`endif
    output logic                  branch_taken_out,
    output logic [DATA_W-1:0]     branch_address_out,
    output logic [3:0]            status_reg_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic [REG_ADDR_W-1:0] wb_reg_dest_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     store_data_out
);

    logic [DATA_W-1:0] rn;
    logic [DATA_W-1:0] rm;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] opb;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] result;
    logic [3:0]        nzcv;
    logic              cin;
    logic              carry_in;
    logic              arith;
    logic              sub_op;
    logic              overflow;
    logic              cmd_valid;

`ifdef EXE_FORWARDING_EN
    assign rn = fwd_mux(fwd_sel_rn, val_rn_in, mem_fwd_value, wb_fwd_value);
    assign rm = fwd_mux(fwd_sel_rm, val_rm_in, mem_fwd_value, wb_fwd_value);
`else
    assign rn = val_rn_in;
    assign rm = val_rm_in;
`endif

    assign branch_taken_out   = branch_taken_in;
    assign branch_address_out = pc_plus_four_in + (branch_immediate_in << 2);

    val2_generator #(.DATA_W(DATA_W)) u_val2 (
        .val_rm             (rm),
        .shifter_operand    (instr_shifter_opperand_in),
        .instr_is_immediate (instr_is_immediate_in),
        .mem_access         (mem_r_en_in | mem_w_en_in),
        .val2               (val2)
    );

    // One adder serves all four arithmetic ops: subtraction adds ~Val2 with a
    // carry-in of 1 (SUB) or Cin (SBC), so sum[DATA_W] is directly NOT borrow.
    always_comb begin
        cin       = status_bits_in[FLAG_C];
        sub_op    = execute_command_in == CMD_SUB || execute_command_in == CMD_SBC;
        arith     = sub_op || execute_command_in == CMD_ADD || execute_command_in == CMD_ADC;
        cmd_valid = execute_command_in >= CMD_MOV && execute_command_in <= CMD_MVN;
        opb       = sub_op ? ~val2 : val2;
        carry_in  = execute_command_in == CMD_SUB ? 1'b1 :
                    execute_command_in == CMD_ADD ? 1'b0 : cin;
        sum       = {1'b0, rn} + {1'b0, opb} + {{DATA_W{1'b0}}, carry_in};
        overflow  = (rn[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != rn[DATA_W-1]);
        case (execute_command_in)
            CMD_MOV: result = val2;
            CMD_MVN: result = ~val2;
            CMD_ADD,
            CMD_ADC,
            CMD_SUB,
            CMD_SBC: result = sum[DATA_W-1:0];
            CMD_AND: result = rn & val2;
            CMD_ORR: result = rn | val2;
            CMD_EOR: result = rn ^ val2;
            default: result = '0;
        endcase
        nzcv[FLAG_N] = result[DATA_W-1];
        nzcv[FLAG_Z] = result == '0;
        nzcv[FLAG_C] = arith ? sum[DATA_W] : status_bits_in[FLAG_C];
        nzcv[FLAG_V] = arith ? overflow : status_bits_in[FLAG_V];
    end

    // Undefined opcodes leave the status register untouched even with S set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_reg_out <= '0;
        end else if (!freeze && do_update_sr_in && cmd_valid) begin
            status_reg_out <= nzcv;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_out       <= 1'b0;
            mem_r_en_out    <= 1'b0;
            mem_w_en_out    <= 1'b0;
            wb_reg_dest_out <= '0;
            alu_result_out  <= '0;
            store_data_out  <= '0;
        end else if (!freeze) begin
            wb_en_out       <= wb_en_in;
            mem_r_en_out    <= mem_r_en_in;
            mem_w_en_out    <= mem_w_en_in;
            wb_reg_dest_out <= wb_reg_dest_in;
            alu_result_out  <= result;
            store_data_out  <= rm;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scoreboard bench for exe_stage with a behavioural reference model.
module tb_exe_stage;
    import exe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b1;
    logic        wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0, branch_taken_in = 0;
    logic        do_update_sr_in = 0, instr_is_immediate_in = 0;
    logic [3:0]  execute_command_in = 0, wb_reg_dest_in = 0, status_bits_in = 0;
    logic [31:0] pc_plus_four_in = 0, branch_immediate_in = 0, val_rn_in = 0, val_rm_in = 0;
    logic [11:0] instr_shifter_opperand_in = 0;
    logic        branch_taken_out, wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [31:0] branch_address_out, alu_result_out, store_data_out;
    logic [3:0]  status_reg_out, wb_reg_dest_out;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .branch_taken_in(branch_taken_in), .do_update_sr_in(do_update_sr_in),
        .instr_is_immediate_in(instr_is_immediate_in), .execute_command_in(execute_command_in),
        .wb_reg_dest_in(wb_reg_dest_in), .pc_plus_four_in(pc_plus_four_in),
        .branch_immediate_in(branch_immediate_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .instr_shifter_opperand_in(instr_shifter_opperand_in), .status_bits_in(status_bits_in),
`ifdef EXE_FORWARDING_EN
        .fwd_sel_rn(2'b00), .fwd_sel_rm(2'b00), .mem_fwd_value(32'h0), .wb_fwd_value(32'h0),
`endif
        .branch_taken_out(branch_taken_out), .branch_address_out(branch_address_out),
        .status_reg_out(status_reg_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .wb_reg_dest_out(wb_reg_dest_out),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb, mr, mw, bt, s, imm;
        logic [3:0]  cmd, dest, flags;
        logic [31:0] pc, bimm, rn, rm;
        logic [11:0] sh;
    } stim_t;

    typedef struct {
        logic        wb, mr, mw;
        logic [3:0]  dest, sr;
        logic [31:0] res, store;
    } exp_t;

    exp_t       q[$];
    exp_t       held;
    logic [3:0] m_sr = 4'h0;
    bit         mon_en = 1'b0;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return n == 0 ? x : (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] m_val2(input stim_t s);
        int n;
        if (s.mr || s.mw) return {20'd0, s.sh};
        if (s.imm) return ror32({24'd0, s.sh[7:0]}, 2 * int'(s.sh[11:8]));
        n = int'(s.sh[11:7]);
        case (s.sh[6:5])
            2'b00:   return s.rm << n;
            2'b01:   return s.rm >> n;
            2'b10:   return 32'($signed(s.rm) >>> n);
            default: return ror32(s.rm, n);
        endcase
    endfunction

    // Flags from exact integer arithmetic: C from the unsigned result/borrow,
    // V from whether the true signed result fits in 32 bits.
    task automatic m_alu(input stim_t s, output logic [31:0] r, output logic [3:0] f, output bit ok);
        logic [31:0] b;
        longint      u, sg, k;
        logic        c, v;
        b  = m_val2(s);
        c  = s.flags[1];
        v  = s.flags[0];
        ok = 1;
        case (s.cmd)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd6: r = s.rn & b;
            4'd7: r = s.rn | b;
            4'd8: r = s.rn ^ b;
            4'd2, 4'd3: begin
                k  = (s.cmd == 4'd3 && c) ? 1 : 0;
                u  = longint'(s.rn) + longint'(b) + k;
                sg = longint'($signed(s.rn)) + longint'($signed(b)) + k;
                r  = u[31:0];
                c  = u > 64'sd4294967295;
                v  = sg > 64'sd2147483647 || sg < -64'sd2147483648;
            end
            4'd4, 4'd5: begin
                k  = (s.cmd == 4'd5 && !c) ? 1 : 0;
                u  = longint'(s.rn) - longint'(b) - k;
                sg = longint'($signed(s.rn)) - longint'($signed(b)) - k;
                r  = u[31:0];
                c  = u >= 0;
                v  = sg > 64'sd2147483647 || sg < -64'sd2147483648;
            end
            default: begin
                r  = 32'h0;
                ok = 0;
            end
        endcase
        f = {r[31], r == 32'h0, c, v};
    endtask

    function automatic stim_t blank();
        stim_t s;
        s = '{wb: 0, mr: 0, mw: 0, bt: 0, s: 0, imm: 0, cmd: 0, dest: 0, flags: 0,
              pc: 0, bimm: 0, rn: 0, rm: 0, sh: 0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s       = blank();
        s.wb    = 1'($urandom);
        s.mr    = ($urandom_range(0, 5) == 0);
        s.mw    = !s.mr && ($urandom_range(0, 5) == 0);
        s.bt    = 1'($urandom);
        s.imm   = 1'($urandom);
        s.cmd   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        s.s     = (s.cmd >= 4'd1 && s.cmd <= 4'd9) && 1'($urandom);
        s.dest  = 4'($urandom);
        s.flags = 4'($urandom);
        s.pc    = $urandom;
        s.bimm  = $urandom;
        s.rn    = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
        s.rm    = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
        s.sh    = 12'($urandom);
        return s;
    endfunction

    task automatic issue(input stim_t s, input bit frz);
        logic [31:0] r;
        logic [3:0]  f;
        bit          ok;
        exp_t        e;
        @(negedge clk);
        freeze = frz;
        wb_en_in = s.wb; mem_r_en_in = s.mr; mem_w_en_in = s.mw; branch_taken_in = s.bt;
        do_update_sr_in = s.s; instr_is_immediate_in = s.imm; execute_command_in = s.cmd;
        wb_reg_dest_in = s.dest; status_bits_in = s.flags; pc_plus_four_in = s.pc;
        branch_immediate_in = s.bimm; val_rn_in = s.rn; val_rm_in = s.rm;
        instr_shifter_opperand_in = s.sh;
        m_alu(s, r, f, ok);
        if (!frz) begin
            if (s.s && ok) m_sr = f;
            e = '{wb: s.wb, mr: s.mr, mw: s.mw, dest: s.dest, sr: m_sr, res: r, store: s.rm};
            q.push_back(e);
        end
        #1;
        chk("branch_taken", 32'(branch_taken_out), 32'(s.bt));
        chk("branch_addr", branch_address_out, s.pc + s.bimm * 4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        freeze = 1'b1;
        rst    = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("rst_alu_result", alu_result_out, 32'h0);
        chk("rst_store_data", store_data_out, 32'h0);
        chk("rst_sr", 32'(status_reg_out), 32'h0);
        chk("rst_ctrl", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'h0);
        chk("rst_dest", 32'(wb_reg_dest_out), 32'h0);
        @(negedge clk);
        @(negedge clk);
        q.delete();
        m_sr   = 4'h0;
        held   = '{wb: 0, mr: 0, mw: 0, dest: 0, sr: 0, res: 0, store: 0};
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: on every captured edge pop the next expected EX/MEM state;
    // on frozen edges the previous state must still be held.
    initial begin
        bit fr, en;
        forever begin
            @(posedge clk);
            fr = freeze;
            en = mon_en;
            #1;
            if (en) begin
                if (!fr) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
                    end else begin
                        held = q.pop_front();
                    end
                end
                chk("wb_en_out", 32'(wb_en_out), 32'(held.wb));
                chk("mem_r_en_out", 32'(mem_r_en_out), 32'(held.mr));
                chk("mem_w_en_out", 32'(mem_w_en_out), 32'(held.mw));
                chk("wb_reg_dest_out", 32'(wb_reg_dest_out), 32'(held.dest));
                chk("alu_result_out", alu_result_out, held.res);
                chk("store_data_out", store_data_out, held.store);
                chk("status_reg_out", 32'(status_reg_out), 32'(held.sr));
            end
        end
    end

    initial begin
        stim_t s;
        do_reset();
        @(negedge clk);

        s = blank(); s.sh = 12'h2FF; s.imm = 1; s.cmd = 4'b0001; s.wb = 1; s.dest = 4'd3;
        issue(s, 0);
        s = blank(); s.rn = 32'h7FFFFFFF; s.sh = 12'h001; s.imm = 1; s.cmd = 4'b0010; s.s = 1; s.wb = 1;
        issue(s, 0);
        s = blank(); s.rn = 32'd5; s.sh = 12'h005; s.imm = 1; s.cmd = 4'b0100; s.s = 1;
        issue(s, 0);
        s = blank(); s.pc = 32'h100; s.bimm = 32'hFFFFFFFE; s.bt = 1;
        issue(s, 0);
        s = blank(); s.mw = 1; s.rn = 32'h1000; s.rm = 32'hCAFEF00D; s.sh = 12'hABC; s.cmd = 4'b0010;
        issue(s, 0);
        s = blank(); s.rn = 32'hFFFFFFFF; s.rm = 32'h1; s.cmd = 4'b0011; s.flags = 4'b0010; s.s = 1; s.wb = 1;
        issue(s, 1);
        issue(s, 1);
        issue(s, 0);
        s = blank(); s.rn = 32'h0; s.rm = 32'h80000000; s.sh = 12'b00011_10_0_0000; s.cmd = 4'b0101; s.s = 1;
        issue(s, 0);
        s = blank(); s.cmd = 4'b1011; s.rn = 32'h1234; s.wb = 1;
        issue(s, 0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            issue(rand_stim(), $urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        freeze = 1'b1;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule
